// File: rtl/bram_dp.sv
// True dual-port word RAM with byte enables, 1- or 2-cycle read latency,
// a post-reset clear sequencer and per-port out-of-range error pulses.
module bram_dp #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEPTH          = 16384,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_rd_en,
  input  logic                  a_wr_en,
  input  logic [DATA_W/8-1:0]   a_be,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  output logic [DATA_W-1:0]     a_rdata,
  output logic                  a_rvalid,
  output logic                  a_err,
  input  logic                  b_rd_en,
  input  logic                  b_wr_en,
  input  logic [DATA_W/8-1:0]   b_be,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_wdata,
  output logic [DATA_W-1:0]     b_rdata,
  output logic                  b_rvalid,
  output logic                  b_err,
  output logic                  busy
);

  localparam int unsigned NBE    = DATA_W / 8;
  localparam int unsigned OFF_W  = (NBE > 1) ? $clog2(NBE) : 0;
  localparam int unsigned IDX_W  = ADDR_W - OFF_W;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state_q, state_d;
  logic [MEM_AW-1:0]   cnt_q, cnt_d;
  logic                busy_q;
  logic                clr_we;
  logic                accept;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Port A is index 0, port B is index 1 throughout.
  logic [1:0]          p_rd, p_wr;
  logic [NBE-1:0]      p_be    [2];
  logic [ADDR_W-1:0]   p_addr  [2];
  logic [DATA_W-1:0]   p_wdata [2];

  logic [IDX_W-1:0]    idx  [2];
  logic [MEM_AW-1:0]   midx [2];
  logic [1:0]          in_rng, wr_ok;
  logic                same_word;

  logic [DATA_W-1:0]   o_d [2];
  logic [1:0]          o_v, o_e;

  assign p_rd       = {b_rd_en, a_rd_en};
  assign p_wr       = {b_wr_en, a_wr_en};
  assign p_be[0]    = a_be;
  assign p_be[1]    = b_be;
  assign p_addr[0]  = a_addr;
  assign p_addr[1]  = b_addr;
  assign p_wdata[0] = a_wdata;
  assign p_wdata[1] = b_wdata;

  assign accept    = ~busy_q & ~rst;
  assign same_word = (midx[0] == midx[1]);
  assign busy      = busy_q;

  // Byte-offset address bits carry no meaning for a word RAM.
  if (OFF_W > 0) begin : g_off
    logic unused_lo;
    assign unused_lo = ^{p_addr[0][OFF_W-1:0], p_addr[1][OFF_W-1:0]};
  end

  // Clear sequencer: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == CLEAR);
    end
  end

  // Clear sequencer: next state, counter and zero-write strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        if (CLEAR_ON_RESET != 0) begin
          clr_we = ~rst;
          cnt_d  = cnt_q + MEM_AW'(1);
          if (cnt_q == MEM_AW'(DEPTH - 1)) begin
            state_d = READY;
          end
        end else begin
          state_d = READY;
        end
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // Write path: port A owns any byte both ports enable on the same word.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < NBE; i++) begin
        if (wr_ok[0] && p_be[0][i]) begin
          mem[midx[0]][8*i +: 8] <= p_wdata[0][8*i +: 8];
        end
        if (wr_ok[1] && p_be[1][i] &&
            !(wr_ok[0] && p_be[0][i] && same_word)) begin
          mem[midx[1]][8*i +: 8] <= p_wdata[1][8*i +: 8];
        end
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic              rd_acc;
    logic              err_req;
    logic              s1_v;
    logic              s1_e;
    logic [DATA_W-1:0] s1_d;

    assign idx[p]    = p_addr[p][ADDR_W-1:OFF_W];
    assign midx[p]   = idx[p][MEM_AW-1:0];
    assign in_rng[p] = (32'(idx[p]) < DEPTH);
    assign wr_ok[p]  = p_wr[p] & accept & in_rng[p];
    assign rd_acc    = p_rd[p] & accept;
    assign err_req   = (p_rd[p] | p_wr[p]) & accept & ~in_rng[p];

    // First read stage; the nonblocking read of mem gives read-first ordering.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_v <= 1'b0;
        s1_e <= 1'b0;
        s1_d <= '0;
      end else begin
        s1_v <= rd_acc;
        s1_e <= err_req;
        if (rd_acc) begin
          s1_d <= in_rng[p] ? mem[midx[p]] : '0;
        end
      end
    end

    if (RD_LATENCY >= 2) begin : g_lat2
      logic              s2_v;
      logic              s2_e;
      logic [DATA_W-1:0] s2_d;

      // Extra output register; data holds between reads.
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_v <= 1'b0;
          s2_e <= 1'b0;
          s2_d <= '0;
        end else begin
          s2_v <= s1_v;
          s2_e <= s1_e;
          if (s1_v) begin
            s2_d <= s1_d;
          end
        end
      end

      assign o_d[p] = s2_d;
      assign o_v[p] = s2_v;
      assign o_e[p] = s2_e;
    end else begin : g_lat1
      assign o_d[p] = s1_d;
      assign o_v[p] = s1_v;
      assign o_e[p] = s1_e;
    end
  end

  assign a_rdata  = o_d[0];
  assign a_rvalid = o_v[0];
  assign a_err    = o_e[0];
  assign b_rdata  = o_d[1];
  assign b_rvalid = o_v[1];
  assign b_err    = o_e[1];

endmodule
